axi4_slave_ctrl: RTL

AXI4 slave controller that sequences the single-port `axi4_memory` word array. It accepts AXI4 write and read bursts, arbitrates between them, translates each beat into one memory access, and returns B/R responses with SLVERR for illegal or out-of-range bursts. It sits between the AXI interconnect and `axi4_memory` and is the only master of the memory port.

---
 rtl/axi4_slave_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_slave_ctrl.sv
// AXI4 slave sequencing a single-port word memory; one burst at a time, SLVERR on illegal/out-of-range bursts.
// Write: 1 beat/cycle, mem write 1 cycle after W; read: RVALID 3 cycles after AR/R handshake; VALID held until READY.
module axi4_slave_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int TW = MEM_ADDR_WIDTH + 9;
  localparam logic [TW-1:0] DEPTH_W = TW'(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_MEM, RD_WAIT, RD_DATA} state_t;

  state_t                state_q, state_d;
  logic                  prio_w_q, prio_w_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  werr_q, werr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  grant_w, grant_r;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [7:0]            a_len;
  logic [2:0]            a_size;
  logic [1:0]            a_burst;
  logic [AW-1:0]         a_word, a_lenw;
  logic [TW-1:0]         a_top;
  logic                  a_wrap_ok, a_err;
  logic                  last_beat, werr_nxt;
  logic [AW-1:0]         addr_nxt;
  logic                  unused_ok;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] l,
                                               input logic [1:0] b);
    logic [AW-1:0] m;
    m = AW'(l);
    case (b)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~m) | ((a + AW'(1)) & m);
      default: next_addr = a + AW'(1);
    endcase
  endfunction

  // A lone request wins; on a tie the channel not granted last wins.
  assign grant_w = AWVALID && (!ARVALID || prio_w_q);
  assign grant_r = ARVALID && !grant_w;
  assign AWREADY = (state_q == IDLE) && grant_w;
  assign ARREADY = (state_q == IDLE) && grant_r;
  assign WREADY  = (state_q == WR_DATA);
  assign BVALID  = (state_q == WR_RESP);
  assign RVALID  = (state_q == RD_DATA);

  assign a_addr  = grant_w ? AWADDR  : ARADDR;
  assign a_len   = grant_w ? AWLEN   : ARLEN;
  assign a_size  = grant_w ? AWSIZE  : ARSIZE;
  assign a_burst = grant_w ? AWBURST : ARBURST;
  assign a_word  = a_addr[AW+1:2];
  assign a_lenw  = AW'(a_len);
  assign unused_ok = ^a_addr[1:0];

  assign a_wrap_ok = (a_len == 8'd1) || (a_len == 8'd3) || (a_len == 8'd7) || (a_len == 8'd15);

  always_comb begin
    case (a_burst)
      2'b00:   a_top = TW'(a_word);
      2'b01:   a_top = TW'(a_word) + TW'(a_len);
      2'b10:   a_top = TW'((a_word & ~a_lenw) | a_lenw);
      default: a_top = '0;
    endcase
  end

  assign a_err = (a_size != 3'b010) || (a_burst == 2'b11) ||
                 ((a_burst == 2'b10) && !a_wrap_ok) || (a_top >= DEPTH_W) ||
                 (|a_addr[ADDR_WIDTH-1:AW+2]);

  assign last_beat = (cnt_q == len_q);
  assign werr_nxt  = werr_q || (WLAST != last_beat);
  assign addr_nxt  = next_addr(addr_q, len_q, burst_q);

  always_comb begin
    state_d     = state_q;
    prio_w_d    = prio_w_q;
    addr_d      = addr_q;
    len_d       = len_q;
    burst_d     = burst_q;
    err_d       = err_q;
    werr_d      = werr_q;
    cnt_d       = cnt_q;
    bresp_d     = bresp_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_w || grant_r) begin
          addr_d   = a_word;
          len_d    = a_len;
          burst_d  = a_burst;
          err_d    = a_err;
          werr_d   = 1'b0;
          cnt_d    = '0;
          prio_w_d = grant_r;
          if (grant_w) begin
            state_d = WR_DATA;
          end else begin
            // Launch the first read now so the access lands in RD_MEM.
            mem_en_d   = !a_err;
            mem_addr_d = a_word;
            state_d    = RD_MEM;
          end
        end
      end
      WR_DATA: begin
        if (WVALID) begin
          mem_en_d    = !err_q;
          mem_we_d    = !err_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = WDATA;
          addr_d      = addr_nxt;
          cnt_d       = cnt_q + 8'd1;
          werr_d      = werr_nxt;
          if (last_beat) begin
            bresp_d = (err_q || werr_nxt) ? 2'b10 : 2'b00;
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (BREADY) state_d = IDLE;
      end
      RD_MEM: state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = err_q ? '0 : mem_rdata;
        rresp_d = err_q ? 2'b10 : 2'b00;
        rlast_d = last_beat;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (RREADY) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            addr_d     = addr_nxt;
            mem_addr_d = addr_nxt;
            mem_en_d   = !err_q;
            cnt_d      = cnt_q + 8'd1;
            state_d    = RD_MEM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_w_q    <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      werr_q      <= 1'b0;
      cnt_q       <= '0;
      bresp_q     <= '0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_w_q    <= prio_w_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      werr_q      <= werr_d;
      cnt_q       <= cnt_d;
      bresp_q     <= bresp_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign BRESP     = bresp_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign RLAST     = rlast_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
